// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared states, winner codes and default constants for the pong controller
package pong_pkg;

    localparam int DEF_TICK_DIV    = 500000;
    localparam int DEF_WIN_SCORE   = 7;
    localparam int DEF_SERVE_TICKS = 60;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } pong_state_e;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// rtl/pong_tick_gen.sv - free-running divider producing a registered 1-cycle tick every DIV clocks
module pong_tick_gen
    import pong_pkg::*;
#(
    parameter int DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == LAST);
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game FSM: serve timing, scoring, win detection and ball control
// Optional rally speed-up is enabled with PONG_RALLY_SPEEDUP_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int SERVE_TICKS = DEF_SERVE_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_btn,
    input  logic       miss_right,
    input  logic       miss_left,
    input  logic       paddle_hit,
    output logic       tick,
    output logic       ball_en,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] winner,
    output logic [1:0] speed_level,
    output logic [2:0] state
);

    localparam logic [3:0]  WIN4       = 4'(WIN_SCORE);
    localparam logic [15:0] SERVE_LAST = 16'(SERVE_TICKS - 1);

    pong_state_e state_q, state_d;
    logic [15:0] serve_cnt_q, serve_cnt_d;
    logic [3:0]  score_p1_q, score_p1_d;
    logic [3:0]  score_p2_q, score_p2_d;
    logic [1:0]  winner_q, winner_d;
    logic        serve_dir_q, serve_dir_d;
    logic        ball_en_q, ball_en_d;
    logic        ball_reset_q, ball_reset_d;
    logic        start_prev_q;
    logic        restart;
    logic        tick_w;

    pong_tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_w)
    );

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        restart     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_btn) restart = 1'b1;
            end
            ST_SERVE: begin
                if (tick_w) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_d     = ST_PLAY;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 16'd1;
                    end
                end
            end
            ST_PLAY: begin
                // miss_right has priority so a coincident double miss scores only once
                if (miss_right) begin
                    score_p2_d  = sat_inc4(score_p2_q);
                    serve_dir_d = 1'b0;
                    state_d     = ST_POINT;
                end else if (miss_left) begin
                    score_p1_d  = sat_inc4(score_p1_q);
                    serve_dir_d = 1'b1;
                    state_d     = ST_POINT;
                end
            end
            ST_POINT: begin
                if (score_p1_q == WIN4) begin
                    winner_d = WINNER_P1;
                    state_d  = ST_GAMEOVER;
                end else if (score_p2_q == WIN4) begin
                    winner_d = WINNER_P2;
                    state_d  = ST_GAMEOVER;
                end else begin
                    serve_cnt_d = '0;
                    state_d     = ST_SERVE;
                end
            end
            ST_GAMEOVER: begin
                if (start_btn && !start_prev_q) restart = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (restart) begin
            score_p1_d  = '0;
            score_p2_d  = '0;
            winner_d    = WINNER_NONE;
            serve_cnt_d = '0;
            state_d     = ST_SERVE;
        end

        ball_en_d    = (state_d == ST_PLAY);
        ball_reset_d = restart || (state_d == ST_POINT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            serve_cnt_q  <= '0;
            score_p1_q   <= '0;
            score_p2_q   <= '0;
            winner_q     <= WINNER_NONE;
            serve_dir_q  <= 1'b0;
            ball_en_q    <= 1'b0;
            ball_reset_q <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            serve_cnt_q  <= serve_cnt_d;
            score_p1_q   <= score_p1_d;
            score_p2_q   <= score_p2_d;
            winner_q     <= winner_d;
            serve_dir_q  <= serve_dir_d;
            ball_en_q    <= ball_en_d;
            ball_reset_q <= ball_reset_d;
            start_prev_q <= start_btn;
        end
    end

`ifdef PONG_RALLY_SPEEDUP_EN
    logic       enter_serve;
    logic [1:0] hit_cnt_q, hit_cnt_d;
    logic [1:0] speed_q, speed_d;

    always_comb begin
        enter_serve = (state_d == ST_SERVE) && (state_q != ST_SERVE);
        hit_cnt_d   = hit_cnt_q;
        speed_d     = speed_q;
        if (enter_serve) begin
            hit_cnt_d = '0;
            speed_d   = '0;
        end else if (state_q == ST_PLAY && paddle_hit) begin
            hit_cnt_d = hit_cnt_q + 2'd1;
            if (hit_cnt_q == 2'd3 && speed_q != 2'd3) speed_d = speed_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q <= '0;
            speed_q   <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            speed_q   <= speed_d;
        end
    end

    assign speed_level = speed_q;
`else
    logic unused_paddle_hit;
    assign unused_paddle_hit = paddle_hit;
    assign speed_level       = 2'd0;
`endif

    assign tick       = tick_w;
    assign ball_en    = ball_en_q;
    assign ball_reset = ball_reset_q;
    assign serve_dir  = serve_dir_q;
    assign score_p1   = score_p1_q;
    assign score_p2   = score_p2_q;
    assign winner     = winner_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - self-checking bench for pong_game_ctrl with a ball_reset scoreboard
module tb_pong_game_ctrl;
    import pong_pkg::*;

    localparam int TDIV = 4;
    localparam int WS   = 3;
    localparam int STK  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_btn = 1'b0;
    logic       miss_right = 1'b0;
    logic       miss_left = 1'b0;
    logic       paddle_hit = 1'b0;
    logic       tick, ball_en, ball_reset, serve_dir;
    logic [3:0] score_p1, score_p2;
    logic [1:0] winner, speed_level;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] st;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       dir;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    pong_game_ctrl #(
        .TICK_DIV    (TDIV),
        .WIN_SCORE   (WS),
        .SERVE_TICKS (STK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_btn   (start_btn),
        .miss_right  (miss_right),
        .miss_left   (miss_left),
        .paddle_hit  (paddle_hit),
        .tick        (tick),
        .ball_en     (ball_en),
        .ball_reset  (ball_reset),
        .serve_dir   (serve_dir),
        .score_p1    (score_p1),
        .score_p2    (score_p2),
        .winner      (winner),
        .speed_level (speed_level),
        .state       (state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_br(input logic [2:0] st, input int p1, input int p2, input logic dir);
        exp_t e;
        e.st  = st;
        e.p1  = 4'(p1);
        e.p2  = 4'(p2);
        e.dir = dir;
        sb_q.push_back(e);
    endtask

    // every ball_reset pulse must match the next queued expectation
    always @(negedge clk) begin
        if (!rst && ball_reset) begin
            if (sb_q.size() == 0) begin
                chk("ball_reset_unexpected", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("br_state", state, mon_e.st);
                chk("br_score_p1", score_p1, mon_e.p1);
                chk("br_score_p2", score_p2, mon_e.p2);
                chk("br_serve_dir", serve_dir, mon_e.dir);
            end
        end
    end

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_state"}, state, ST_IDLE);
        chk({pfx, "_tick"}, tick, 0);
        chk({pfx, "_ball_en"}, ball_en, 0);
        chk({pfx, "_ball_reset"}, ball_reset, 0);
        chk({pfx, "_serve_dir"}, serve_dir, 0);
        chk({pfx, "_score_p1"}, score_p1, 0);
        chk({pfx, "_score_p2"}, score_p2, 0);
        chk({pfx, "_winner"}, winner, WINNER_NONE);
        chk({pfx, "_speed"}, speed_level, 0);
    endtask

    task automatic drive_in(input logic mr, input logic ml, input logic ph);
        @(negedge clk);
        miss_right = mr;
        miss_left  = ml;
        paddle_hit = ph;
        @(negedge clk);
        miss_right = 1'b0;
        miss_left  = 1'b0;
        paddle_hit = 1'b0;
    endtask

    task automatic press_start();
        @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
    endtask

    task automatic wait_play();
        int n    = 0;
        int cyc  = 0;
        int last = -10;
        while (state != ST_PLAY && cyc < 60) begin
            if (state == ST_SERVE && tick) begin
                n++;
                last = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        chk("serve_ticks", n, STK);
        chk("play_latency", cyc - last, 1);
        chk("ball_en_play", ball_en, 1);
    endtask

    initial begin
        int c;
        int exp_spd;

        repeat (2) @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b0;

        c = 0;
        while (!tick && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("tick_seen", tick, 1);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!tick && c < 20);
        chk("tick_period", c, TDIV);
        chk("idle_hold", state, ST_IDLE);
        chk("idle_ball_en", ball_en, 0);

        expect_br(ST_SERVE, 0, 0, 1'b0);
        press_start();
        chk("start_state", state, ST_SERVE);
        wait_play();

        expect_br(ST_POINT, 0, 1, 1'b0);
        drive_in(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("point_to_serve", state, ST_SERVE);
        wait_play();

        expect_br(ST_POINT, 0, 2, 1'b0);
        drive_in(1'b1, 1'b1, 1'b0);
        chk("both_miss_p1", score_p1, 0);
        @(negedge clk);
        chk("both_to_serve", state, ST_SERVE);

        for (int k = 1; k <= 3; k++) begin
            wait_play();
            if (k == 3) start_btn = 1'b1;
            expect_br(ST_POINT, k, 2, 1'b1);
            drive_in(1'b0, 1'b1, 1'b0);
            @(negedge clk);
            if (k < 3) begin
                chk("left_to_serve", state, ST_SERVE);
            end else begin
                chk("gameover_state", state, ST_GAMEOVER);
                chk("winner_p1", winner, WINNER_P1);
                chk("gameover_ball_en", ball_en, 0);
            end
        end

        repeat (4) @(negedge clk);
        chk("held_no_restart", state, ST_GAMEOVER);
        drive_in(1'b1, 1'b0, 1'b0);
        chk("go_miss_ignored_p2", score_p2, 2);
        chk("go_score_p1_hold", score_p1, 3);
        start_btn = 1'b0;
        repeat (2) @(negedge clk);
        chk("release_no_restart", state, ST_GAMEOVER);

        expect_br(ST_SERVE, 0, 0, 1'b1);
        press_start();
        chk("restart_state", state, ST_SERVE);
        chk("restart_winner", winner, WINNER_NONE);
        wait_play();

        for (int h = 1; h <= 13; h++) begin
            drive_in(1'b0, 1'b0, 1'b1);
`ifdef PONG_RALLY_SPEEDUP_EN
            exp_spd = (h / 4 > 3) ? 3 : h / 4;
`else
            exp_spd = 0;
`endif
            chk("speed_level", speed_level, exp_spd);
        end

        expect_br(ST_POINT, 0, 1, 1'b0);
        drive_in(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("speed_serve_state", state, ST_SERVE);
        chk("speed_cleared", speed_level, 0);
        wait_play();

        #2 rst = 1'b1;
        #1 check_reset_vals("rst_async");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("idle_after_rst", state, ST_IDLE);
        chk("idle_after_rst_p2", score_p2, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
